// File: rtl/cpu_bus_interface_pkg.sv
// Shared codes for cpu_bus_interface: the I/O controller request codes (io_*)
// and the bus FSM state codes (bi_*), kept in step with the shared type.v.
package cpu_bus_interface_pkg;

  localparam logic [2:0] IO_IDLE        = 3'd0;
  localparam logic [2:0] IO_READ_BEGIN  = 3'd1;
  localparam logic [2:0] IO_READ_WAIT   = 3'd2;
  localparam logic [2:0] IO_WRITE_BEGIN = 3'd3;
  localparam logic [2:0] IO_WRITE_WAIT  = 3'd4;

  typedef enum logic [1:0] {
    BI_IDLE  = 2'd0,
    BI_READ  = 2'd1,
    BI_WRITE = 2'd2,
    BI_DONE  = 2'd3
  } bi_state_e;

endpackage

// File: rtl/cpu_bus_interface.sv
// Turns I/O controller read/write requests into strobe/ack bus transactions.
// Optional strobe timeout is built only when CPU_BUS_TIMEOUT_EN is defined.
module cpu_bus_interface
  import cpu_bus_interface_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            io_state,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  bus_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output bi_state_e             dbg_state
);

  // Bus handshake: mem_rd/mem_wr are levels held until a rising clk edge sees
  // mem_ack=1; that edge completes the access and mem_rdata is valid with it.
  bi_state_e             state_q, state_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  ready_q, ready_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  expired;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q, bus_error_d;

  // The strobe has been up TIMEOUT_CYCLES cycles at the edge where this holds.
  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    ready_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
`ifdef CPU_BUS_TIMEOUT_EN
    cnt_d       = '0;
    bus_error_d = bus_error_q;
`endif
    case (state_q)
      BI_IDLE: begin
        if (io_state == IO_READ_BEGIN) begin
          mem_addr_d = cpu_addr;
          mem_rd_d   = 1'b1;
          state_d    = BI_READ;
`ifdef CPU_BUS_TIMEOUT_EN
          bus_error_d = 1'b0;
`endif
        end else if (io_state == IO_WRITE_BEGIN) begin
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_wr_d    = 1'b1;
          state_d     = BI_WRITE;
`ifdef CPU_BUS_TIMEOUT_EN
          bus_error_d = 1'b0;
`endif
        end
      end
      BI_READ, BI_WRITE: begin
        // An ack on the expiry edge still counts as a normal completion.
        if (mem_ack) begin
          if (state_q == BI_READ) cpu_rdata_d = mem_rdata;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = BI_DONE;
        end else if (expired) begin
          if (state_q == BI_READ) cpu_rdata_d = '1;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = BI_DONE;
`ifdef CPU_BUS_TIMEOUT_EN
          bus_error_d = 1'b1;
`endif
        end else begin
`ifdef CPU_BUS_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      BI_DONE: begin
        state_d = BI_IDLE;
      end
      default: state_d = BI_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BI_IDLE;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      ready_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
`ifdef CPU_BUS_TIMEOUT_EN
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      ready_q     <= ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
`ifdef CPU_BUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
`endif
    end
  end

`ifdef CPU_BUS_TIMEOUT_EN
  assign bus_error = bus_error_q;
`else
  assign bus_error = 1'b0;
`endif

  assign ready     = ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign dbg_state = state_q;

endmodule

// File: doc/cpu_bus_interface.md
Name: cpu_bus_interface

Overview:
- Downstream of the CPU I/O controller. Consumes its 3-bit io_state and turns each read/write request into a strobe/acknowledge transaction on the external memory bus.
- Latches the address and write data, and captures read data.
- Returns a one-cycle ready pulse that lets the I/O controller leave its wait state.
- Sits between the CPU core and the memory/peripheral fabric.

Parameters:
- ADDR_WIDTH, 16, width of cpu_addr/mem_addr
- DATA_WIDTH, 16, width of all data buses
- TIMEOUT_CYCLES, 255, max cycles a strobe is held before abort (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- io_state  input  3  request state from the I/O controller, encoded with the io_* constants in type.v
- cpu_addr  input  ADDR_WIDTH  access address from the CPU, valid when io_state is a *_begin code
- cpu_wdata  input  DATA_WIDTH  store data, valid with io_write_begin
- ready  output  1  one-cycle pulse: transaction finished
- cpu_rdata  output  DATA_WIDTH  last captured read data, held until the next read completes
- bus_error  output  1  last transaction aborted by timeout
- mem_addr  output  ADDR_WIDTH  registered bus address
- mem_wdata  output  DATA_WIDTH  registered bus write data
- mem_rd  output  1  read strobe, level, held until acknowledged
- mem_wr  output  1  write strobe, level, held until acknowledged
- mem_ack  input  1  bus acknowledge, sampled at rising clk
- mem_rdata  input  DATA_WIDTH  read data, valid in the cycle mem_ack=1

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-transaction included):
  - state=BI_IDLE, mem_rd=0, mem_wr=0, ready=0, bus_error=0.
  - mem_addr=0, mem_wdata=0, cpu_rdata=0, timeout counter=0.
  - No completion pulse is ever produced for an access cut short by reset.
- States: BI_IDLE, BI_READ, BI_WRITE, BI_DONE (2-bit encoding).
- BI_IDLE:
  - io_state==io_read_begin: mem_addr<=cpu_addr, mem_rd<=1, go to BI_READ.
  - io_state==io_write_begin: mem_addr<=cpu_addr, mem_wdata<=cpu_wdata, mem_wr<=1, go to BI_WRITE.
  - Either begin also clears bus_error.
  - All other io_state values, including undefined codes, are ignored.
- BI_READ:
  - On an edge with mem_ack=1: cpu_rdata<=mem_rdata, mem_rd<=0, ready<=1, go to BI_DONE.
  - mem_ack=0: hold all outputs.
- BI_WRITE: on mem_ack=1: mem_wr<=0, ready<=1, go to BI_DONE. mem_wdata is not changed.
- BI_DONE: ready<=0, go to BI_IDLE.
  - ready is high exactly one cycle, which the I/O controller samples in its *_wait state.
- Latency:
  - Strobe rises 1 cycle after the *_begin code is sampled.
  - With a zero-wait slave (mem_ack high in the first strobe cycle), ready rises 2 cycles after *_begin.
- Back-to-back: a *_begin seen while in BI_DONE is not accepted. The controller cannot issue one before returning to io_idle, so the minimum spacing is guaranteed upstream.
- Strobe rules:
  - mem_rd and mem_wr are never high together.
  - A strobe never drops without a sampled mem_ack, except on reset or timeout.
- mem_ack while idle (no strobe): ignored.
- *_begin codes arriving while in BI_READ/BI_WRITE: ignored, the in-flight access completes normally.

Optional Feature:
- Macro: CPU_BUS_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter clears on strobe assertion and increments each cycle in BI_READ/BI_WRITE without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack: strobe<=0, ready<=1, bus_error<=1, go to BI_DONE.
  - On a read timeout, cpu_rdata<= all ones.
  - An ack in the same cycle as the timeout wins: normal completion, bus_error stays 0.
- When undefined:
  - No counter is built and the block waits indefinitely for mem_ack.
  - bus_error is tied to 0; the port is kept.

Decomposition:
- io_* codes come from the shared type.v.
- The BI_* state codes are added to type.v as `bi_idle/`bi_read/`bi_write/`bi_done, so debug logic can decode them.
- No sub-module is required. The timeout counter may be factored as bus_timeout_counter (enable, clear, expired), instantiated only under CPU_BUS_TIMEOUT_EN.

Test Plan:
- Zero-wait read:
  - Stimulus: io_read_begin, cpu_addr=0x1234; mem_ack=1 with mem_rdata=0xBEEF in the first strobe cycle.
  - Response: mem_rd high 1 cycle with mem_addr=0x1234; ready pulses 1 cycle at begin+2; cpu_rdata=0xBEEF held after.
- Wait-state write:
  - Stimulus: io_write_begin, addr=0x0040, wdata=0x00A5; mem_ack delayed 3 cycles.
  - Response: mem_wr high for exactly 4 cycles; mem_wdata=0x00A5 throughout; ready single pulse; mem_rd stays 0.
- Reset mid-read:
  - Stimulus: assert reset asynchronously (between edges) 2 cycles into a stalled read.
  - Response: mem_rd drops immediately without a clock edge; ready never pulses; the next read then completes normally.
- Ignored traffic:
  - Stimulus: mem_ack pulses while idle, plus undefined io_state codes 3'b111.
  - Response: no strobe, no ready, cpu_rdata unchanged.
- Timeout (macro defined, TIMEOUT_CYCLES=4):
  - Stimulus: read with mem_ack never asserted.
  - Response: strobe drops after 4 cycles; ready pulses; bus_error=1; cpu_rdata=0xFFFF; bus_error clears at the next *_begin.
- Timeout tie (macro defined, TIMEOUT_CYCLES=4):
  - Stimulus: mem_ack arrives exactly in the expiry cycle.
  - Response: normal completion with bus_error=0.
